tpu_seq_ctrl: RTL and testbench

- Parametrised program sequencer for the TPU datapath; successor to the fixed 8-entry, fixed-latency control unit.
- Holds a host-writable instruction memory and steps through it on `start`.
- Drives the systolic-array strobes `load_weight`, `load_input`, `valid` and `store`, plus the `base_address` register.
- New over the previous generation: per-instruction COMPUTE length, busy/done/error status, program load port, PC visibility, guarded end-of-memory behaviour.

---
 rtl/tpu_isa_pkg.sv | 41 ++++
 rtl/tpu_seq_imem.sv | 35 +++
 rtl/tpu_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_isa_pkg.sv
// tpu_isa_pkg
// Purpose: shared instruction-set definitions for the TPU program sequencer.
//   Holds the opcode and sequencer-state enums, default field geometry of an
//   instruction word, and a small assembler helper used by the datapath and
//   by testbench program builders.
// Ports: none (package).
package tpu_isa_pkg;

  // Default instruction word geometry: opcode in the top OPC bits, operand below.
  localparam int INSTR_W_DEF = 16;
  localparam int OPC_W_DEF   = 3;
  localparam int OPC_MSB_DEF = INSTR_W_DEF - 1;
  localparam int OPC_LSB_DEF = INSTR_W_DEF - OPC_W_DEF;
  localparam int ARG_W_DEF   = INSTR_W_DEF - OPC_W_DEF;
  localparam int ARG_MSB_DEF = ARG_W_DEF - 1;

  typedef enum logic [2:0] {
    OP_HALT        = 3'b000,
    OP_LOAD_ADDR   = 3'b001,
    OP_LOAD_WEIGHT = 3'b010,
    OP_LOAD_INPUTS = 3'b011,
    OP_COMPUTE     = 3'b100,
    OP_STORE       = 3'b101,
    OP_WAIT        = 3'b110,
    OP_ILLEGAL     = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } seq_state_t;

  // Builds a default-geometry instruction word from an opcode and operand.
  function automatic logic [INSTR_W_DEF-1:0] encode(input opcode_t op,
                                                    input logic [ARG_W_DEF-1:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/tpu_seq_imem.sv
// tpu_seq_imem
// Purpose: instruction memory for the TPU sequencer. One synchronous write
//   port, one combinational read port. Contents are deliberately not reset so
//   a loaded program survives a sequencer reset.
// Ports:
//   clk    - clock
//   we     - write enable (already qualified by the sequencer state)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data
module tpu_seq_imem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl
// Purpose: program sequencer for the TPU datapath. A host loads the
//   instruction memory while the sequencer is idle, then pulses start; the
//   sequencer fetches and executes words from address 0, driving the
//   systolic-array strobes and the base address register.
// Configuration macro:
//   TPU_SEQ_WAIT_EN - when defined, opcode 110 is WAIT (operand+1 idle EXEC
//                     cycles); when undefined, opcode 110 is illegal.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   start           - run request, honoured only in IDLE or DONE
//   prog_we/addr/data - instruction memory write port (IDLE/DONE only)
//   load_weight, load_input, valid, store - datapath strobes (EXEC only)
//   base_address    - base address register (written by LOAD_ADDR)
//   busy, done      - status: FETCH/EXEC, DONE
//   error           - sticky fault flag (illegal opcode or ran off memory end)
//   pc              - current program counter
module tpu_seq_ctrl
  import tpu_isa_pkg::*;
#(
  parameter int INSTR_W        = INSTR_W_DEF,
  parameter int OPC_W          = OPC_W_DEF,
  parameter int ARG_W          = INSTR_W - OPC_W,
  parameter int IMEM_DEPTH     = 16,
  parameter int PC_W           = $clog2(IMEM_DEPTH),
  parameter int COMPUTE_CYCLES = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic               load_weight,
  output logic               load_input,
  output logic               valid,
  output logic               store,
  output logic [ARG_W-1:0]   base_address,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [PC_W-1:0]    pc
);

  localparam logic [PC_W-1:0]  LAST_PC  = PC_W'(IMEM_DEPTH - 1);
  localparam logic [ARG_W-1:0] DEF_LAST = ARG_W'(COMPUTE_CYCLES - 1);

  seq_state_t         state;
  logic [INSTR_W-1:0] ir;
  logic [ARG_W-1:0]   cnt;
  logic [INSTR_W-1:0] rd_data;
  logic               mem_we;

  logic [OPC_W-1:0]   opc_bits;
  opcode_t            opc;
  logic [ARG_W-1:0]   arg;
  logic [ARG_W-1:0]   last_cnt;
  logic               op_done;
  logic               illegal;
  logic               exec;

  // Program writes are only accepted while the sequencer is not running.
  assign mem_we = prog_we && ((state == S_IDLE) || (state == S_DONE));

  tpu_seq_imem #(
    .DEPTH (IMEM_DEPTH),
    .WIDTH (INSTR_W),
    .AW    (PC_W)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  assign opc_bits = ir[INSTR_W-1 -: OPC_W];
  assign opc      = opcode_t'(opc_bits);
  assign arg      = ir[ARG_W-1:0];
  assign exec     = (state == S_EXEC);

  // Last counter value of the current EXEC; multi-cycle ops share the counter.
  always_comb begin
    last_cnt = '0;
    case (opc)
      OP_COMPUTE: last_cnt = (arg == '0) ? DEF_LAST : (arg - ARG_W'(1));
`ifdef TPU_SEQ_WAIT_EN
      OP_WAIT:    last_cnt = arg;
`endif
      default:    last_cnt = '0;
    endcase
  end

  assign op_done = (cnt == last_cnt);

  always_comb begin
    illegal = 1'b0;
    if (opc == OP_ILLEGAL) illegal = 1'b1;
`ifndef TPU_SEQ_WAIT_EN
    if (opc == OP_WAIT) illegal = 1'b1;
`endif
  end

  // Strobes come straight from the state register and ir, so an asynchronous
  // reset drops them immediately.
  assign load_weight = exec && (opc == OP_LOAD_WEIGHT);
  assign load_input  = exec && (opc == OP_LOAD_INPUTS);
  assign valid       = exec && (opc == OP_COMPUTE);
  assign store       = exec && (opc == OP_STORE);
  assign busy        = (state == S_FETCH) || (state == S_EXEC);
  assign done        = (state == S_DONE);

  // Sequencer FSM: fetch one word, execute it for one or more cycles, then
  // either advance or stop in DONE (HALT, illegal opcode, or end of memory).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= '0;
      cnt          <= '0;
      ir           <= '0;
      base_address <= '0;
      error        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= '0;
            cnt   <= '0;
            error <= 1'b0;
          end
        end
        S_FETCH: begin
          ir    <= rd_data;
          cnt   <= '0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (opc == OP_LOAD_ADDR) begin
            base_address <= arg;
          end
          if (opc == OP_HALT) begin
            state <= S_DONE;
          end else if (illegal) begin
            error <= 1'b1;
            state <= S_DONE;
          end else if (!op_done) begin
            cnt <= cnt + ARG_W'(1);
          end else begin
            cnt <= '0;
            if (pc == LAST_PC) begin
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              pc    <= pc + PC_W'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl
// Purpose: directed self-checking bench for tpu_seq_ctrl. Inputs change and
//   outputs are sampled on the falling clock edge; "cycle N" is the interval
//   that ends with rising edge N, where edge 0 is the one sampling start.
// Ports: none (top-level bench). Honours TPU_SEQ_WAIT_EN for the WAIT case.
module tb_tpu_seq_ctrl;
  import tpu_isa_pkg::*;

  localparam int INSTR_W        = 16;
  localparam int OPC_W          = 3;
  localparam int ARG_W          = 13;
  localparam int IMEM_DEPTH     = 16;
  localparam int PC_W           = 4;
  localparam int COMPUTE_CYCLES = 6;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               prog_we;
  logic [PC_W-1:0]    prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic               load_weight;
  logic               load_input;
  logic               valid;
  logic               store;
  logic [ARG_W-1:0]   base_address;
  logic               busy;
  logic               done;
  logic               error;
  logic [PC_W-1:0]    pc;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  tpu_seq_ctrl #(
    .INSTR_W        (INSTR_W),
    .OPC_W          (OPC_W),
    .ARG_W          (ARG_W),
    .IMEM_DEPTH     (IMEM_DEPTH),
    .PC_W           (PC_W),
    .COMPUTE_CYCLES (COMPUTE_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .load_weight  (load_weight),
    .load_input   (load_input),
    .valid        (valid),
    .store        (store),
    .base_address (base_address),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .pc           (pc)
  );

  // Flag vector order: {load_weight, load_input, valid, store, busy, done, error}
  function automatic logic [31:0] flags();
    return {25'd0, load_weight, load_input, valid, store, busy, done, error};
  endfunction

  function automatic logic [31:0] mk(input bit lw, input bit li, input bit v,
                                     input bit st, input bit bz, input bit dn,
                                     input bit er);
    return {25'd0, lw, li, v, st, bz, dn, er};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives inputs for one cycle (sampled at the next rising edge), then
  // returns at the following falling edge with start/prog_we released.
  task automatic applyStimulus(input logic st, input logic we,
                               input logic [PC_W-1:0] addr,
                               input logic [INSTR_W-1:0] data);
    start     = st;
    prog_we   = we;
    prog_addr = addr;
    prog_data = data;
    @(negedge clk);
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic loadFullProgram();
    applyStimulus(1'b0, 1'b1, 4'd0, 16'h2040);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h4000);
    applyStimulus(1'b0, 1'b1, 4'd2, 16'h6000);
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h8000);
    applyStimulus(1'b0, 1'b1, 4'd4, 16'hA000);
    applyStimulus(1'b0, 1'b1, 4'd5, 16'h0000);
  endtask

  // Expected schedule of the six-word reference program.
  function automatic logic [31:0] fullExpect(input int c);
    return mk(c == 4, c == 6, (c >= 8) && (c <= 13), c == 15, c <= 17, c >= 18, 1'b0);
  endfunction

  function automatic logic [31:0] fullPc(input int c);
    if (c <= 2)  return 32'd0;
    if (c <= 4)  return 32'd1;
    if (c <= 6)  return 32'd2;
    if (c <= 13) return 32'd3;
    if (c <= 15) return 32'd4;
    return 32'd5;
  endfunction

  // Runs the reference program from start; with disturb set, hammers word 0
  // with HALT and re-asserts start while the sequencer is busy.
  task automatic runFull(input string tag, input bit disturb);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    for (int c = 1; c <= 19; c++) begin
      checkOutput($sformatf("%s_flags_c%0d", tag, c), flags(), fullExpect(c));
      checkOutput($sformatf("%s_pc_c%0d", tag, c), 32'(pc), fullPc(c));
      if (c >= 3) checkOutput($sformatf("%s_base_c%0d", tag, c), 32'(base_address), 32'h040);
      if (disturb) begin
        prog_we   = (c <= 6);
        prog_addr = 4'd0;
        prog_data = 16'h0000;
        start     = (c == 4);
      end
      @(negedge clk);
    end
    prog_we = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    // Reset state
    #2;
    checkOutput("reset_flags", flags(), 32'd0);
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_base", 32'(base_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_flags", flags(), 32'd0);

    // Full reference program
    $display("[TB] full program");
    loadFullProgram();
    runFull("full", 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("done_sticky", flags(), mk(0, 0, 0, 0, 0, 1, 0));

    // Reset in the 4th valid cycle, then replay
    $display("[TB] reset mid-compute");
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    repeat (10) @(negedge clk);
    checkOutput("pre_reset_valid", flags(), mk(0, 0, 1, 0, 1, 0, 0));
    #1 reset = 1'b1;
    #1;
    checkOutput("async_reset_flags", flags(), 32'd0);
    checkOutput("async_reset_pc", 32'(pc), 32'd0);
    checkOutput("async_reset_base", 32'(base_address), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    runFull("replay", 1'b0);

    // Writes and start while busy must be ignored
    $display("[TB] writes while busy");
    runFull("busywr", 1'b1);
    runFull("rerun", 1'b0);

    // COMPUTE with explicit length 3
    $display("[TB] compute length");
    applyStimulus(1'b0, 1'b1, 4'd0, 16'h8003);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h0000);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    for (int c = 1; c <= 7; c++) begin
      checkOutput($sformatf("comp3_flags_c%0d", c), flags(),
                  mk(0, 0, (c >= 2) && (c <= 4), 0, c <= 6, c == 7, 0));
      checkOutput($sformatf("comp3_pc_c%0d", c), 32'(pc), (c <= 4) ? 32'd0 : 32'd1);
      @(negedge clk);
    end

    // Illegal opcode at word 1
    $display("[TB] illegal opcode");
    applyStimulus(1'b0, 1'b1, 4'd0, 16'h4000);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'hE000);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      checkOutput($sformatf("illegal_flags_c%0d", c), flags(),
                  mk(c == 2, 0, 0, 0, c <= 4, c == 5, c == 5));
      @(negedge clk);
    end

    // WAIT opcode (error cleared by the accepted start)
    $display("[TB] wait opcode");
    applyStimulus(1'b0, 1'b1, 4'd0, 16'hC004);
    applyStimulus(1'b0, 1'b1, 4'd1, 16'h0000);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
`ifdef TPU_SEQ_WAIT_EN
    for (int c = 1; c <= 9; c++) begin
      checkOutput($sformatf("wait_flags_c%0d", c), flags(), mk(0, 0, 0, 0, c <= 8, c == 9, 0));
      checkOutput($sformatf("wait_pc_c%0d", c), 32'(pc), (c <= 6) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
`else
    for (int c = 1; c <= 3; c++) begin
      checkOutput($sformatf("wait_flags_c%0d", c), flags(), mk(0, 0, 0, 0, c <= 2, c == 3, c == 3));
      @(negedge clk);
    end
`endif

    // Sixteen words without HALT run off the end of memory
    $display("[TB] no halt");
    for (int a = 0; a < IMEM_DEPTH; a++) begin
      applyStimulus(1'b0, 1'b1, 4'(a), encode(OP_LOAD_WEIGHT, '0));
    end
    applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
    for (int c = 1; c <= 33; c++) begin
      checkOutput($sformatf("nohalt_flags_c%0d", c), flags(),
                  mk((c % 2 == 0) && (c <= 32), 0, 0, 0, c <= 32, c == 33, c == 33));
      checkOutput($sformatf("nohalt_pc_c%0d", c), 32'(pc), (c <= 32) ? 32'((c - 1) / 2) : 32'd15);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
